// File: rtl/arb_client_pkg.sv
// arb_client_pkg: width helpers and one-hot decode shared by the arbiter client and its bench
package arb_client_pkg;
  function automatic int PTR_W(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int IDX_W(input int ports);
    return $clog2(ports);
  endfunction
  // Index of the highest set bit; callers qualify the vector as one-hot first
  function automatic int onehot_to_idx(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/req_fifo.sv
// req_fifo: per-port queue with occupancy count; push ignored when full, pop ignored when empty
module req_fifo import arb_client_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         din,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic [CNT_W(DEPTH)-1:0]   count
);
  localparam int PW = PTR_W(DEPTH);
  localparam int CW = CNT_W(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count != CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/arb_req_client.sv
// arb_req_client: per-port FIFOs feeding a fixed-priority arbiter, serialising granted heads to one stream
module arb_req_client import arb_client_pkg::*; #(
  parameter int num_ports = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [num_ports-1:0]          in_valid_i,
  output logic [num_ports-1:0]          in_ready_o,
  input  logic [num_ports*DATA_W-1:0]   in_data_i,
  output logic [num_ports-1:0]          req_o,
  input  logic [num_ports-1:0]          gnt_i,
  output logic                          out_valid_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [IDX_W(num_ports)-1:0]   out_port_o,
  output logic                          err_o
);
  localparam int CW = CNT_W(DEPTH);
  localparam int IW = IDX_W(num_ports);
  logic [CW-1:0] count [num_ports];
  logic [DATA_W-1:0] head [num_ports];
  logic [num_ports-1:0] pop;
  logic onehot, pop_ok;
  logic [IW-1:0] idx;
  assign onehot = gnt_i != '0 && (gnt_i & (gnt_i - num_ports'(1))) == '0;
  assign idx = IW'(onehot_to_idx(32'(gnt_i)));
  assign pop_ok = |pop;
  for (genvar p = 0; p < num_ports; p++) begin : g_port
    assign in_ready_o[p] = count[p] != CW'(DEPTH);
    // A port being popped now only keeps requesting if a further entry remains
    assign req_o[p] = count[p] > CW'(gnt_i[p]);
    assign pop[p] = onehot && gnt_i[p] && count[p] != '0;
    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk_i),
      .rst(rst_i),
      .push(in_valid_i[p]),
      .din(in_data_i[p*DATA_W +: DATA_W]),
      .pop(pop[p]),
      .head(head[p]),
      .count(count[p])
    );
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      out_port_o <= '0;
      err_o <= 1'b0;
    end else begin
      out_valid_o <= pop_ok;
      if (pop_ok) begin
        out_data_o <= head[idx];
        out_port_o <= idx;
      end
      if (gnt_i != '0 && !pop_ok) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arb_req_client.sv
// tb_arb_req_client: directed and random traffic against a queue-based model with an in-loop arbiter
module tb_arb_req_client;
  import arb_client_pkg::*;
  localparam int N = 5;
  localparam int DW = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_valid, in_ready, req, gnt;
  logic [N*DW-1:0] in_data;
  logic out_valid, err;
  logic [DW-1:0] out_data;
  logic [IDX_W(N)-1:0] out_port;
  logic [DW-1:0] q [N][$];
  logic exp_v, exp_err, arb;
  logic [DW-1:0] exp_d;
  logic [IDX_W(N)-1:0] exp_p;
  logic [N-1:0] force_g;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  arb_req_client #(.num_ports(N), .DATA_W(DW), .DEPTH(D)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_data),
    .req_o(req),
    .gnt_i(gnt),
    .out_valid_o(out_valid),
    .out_data_o(out_data),
    .out_port_o(out_port),
    .err_o(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: model the edge, advance, apply the arbiter's registered grant, then compare
  task automatic step();
    logic [N-1:0] nxt, ereq;
    int sz0 [N];
    int idx;
    nxt = rst ? '0 : arb ? (req & (~req + N'(1))) : force_g;
    for (int p = 0; p < N; p++) sz0[p] = q[p].size();
    if (rst) begin
      for (int p = 0; p < N; p++) q[p].delete();
      exp_v = 0; exp_d = '0; exp_p = '0; exp_err = 0;
    end else begin
      idx = onehot_to_idx(32'(gnt));
      if ($countones(gnt) == 1 && sz0[idx] != 0) begin
        exp_v = 1;
        exp_d = q[idx].pop_front();
        exp_p = IDX_W(N)'(idx);
      end else begin
        exp_v = 0;
        if (gnt != '0) exp_err = 1;
      end
      for (int p = 0; p < N; p++)
        if (in_valid[p] && sz0[p] != D) q[p].push_back(in_data[p*DW +: DW]);
    end
    @(posedge clk);
    #1;
    gnt = nxt;
    in_valid = '0;
    rst = 0;
    #1;
    for (int p = 0; p < N; p++) ereq[p] = q[p].size() > int'(gnt[p]);
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("out_data", 64'(out_data), 64'(exp_d));
    chk("out_port", 64'(out_port), 64'(exp_p));
    chk("err", 64'(err), 64'(exp_err));
    chk("req", 64'(req), 64'(ereq));
    for (int p = 0; p < N; p++) chk($sformatf("in_ready%0d", p), 64'(in_ready[p]), 64'(q[p].size() != D));
  endtask
  task automatic push(input int p, input logic [DW-1:0] d);
    in_valid[p] = 1'b1;
    in_data[p*DW +: DW] = d;
  endtask
  initial begin
    rst = 1; in_valid = '0; in_data = '0; gnt = '0; arb = 1; force_g = '0;
    exp_v = 0; exp_d = '0; exp_p = '0; exp_err = 0;
    step();
    step();
    // single entry on port 3
    push(3, 8'hA5);
    step();
    chk("single_req", 64'(req), 64'(5'b01000));
    step();
    chk("single_gnt", 64'(gnt), 64'(5'b01000));
    chk("single_no_early_out", 64'(out_valid), 64'(0));
    step();
    chk("single_out", 64'({out_valid, out_port, out_data}), 64'({1'b1, 3'd3, 8'hA5}));
    repeat (2) step();
    // priority: port 0 {1,2}, port 4 {9}
    push(0, 8'd1); push(4, 8'd9);
    step();
    push(0, 8'd2);
    step();
    repeat (5) step();
    // full FIFO on port 1 with the arbiter held off
    arb = 0; force_g = '0;
    for (int i = 0; i < 5; i++) begin
      push(1, DW'(8'h10 + i));
      step();
    end
    chk("full_ready", 64'(in_ready[1]), 64'(0));
    force_g = 5'b00010;
    step();
    force_g = '0;
    step();
    chk("full_reopen", 64'(in_ready[1]), 64'(1));
    arb = 1;
    push(1, 8'h20);
    step();
    push(1, 8'h21);
    step();
    repeat (6) step();
    // protocol errors
    arb = 0;
    push(0, 8'h30); push(1, 8'h31);
    step();
    force_g = 5'b00011;
    step();
    force_g = '0;
    step();
    chk("multi_gnt_err", 64'(err), 64'(1));
    step();
    rst = 1;
    step();
    force_g = 5'b00100;
    step();
    force_g = '0;
    repeat (3) step();
    chk("empty_gnt_err", 64'(err), 64'(1));
    rst = 1;
    step();
    // reset mid-stream with a grant in flight
    arb = 1;
    push(0, 8'h40); push(2, 8'h42); push(4, 8'h44);
    step();
    push(0, 8'h41); push(2, 8'h43);
    step();
    rst = 1;
    step();
    chk("rst_req", 64'(req), 64'(0));
    step();
    chk("rst_no_out", 64'(out_valid), 64'(0));
    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = N'($urandom);
      in_data = (N*DW)'({$urandom, $urandom});
      rst = $urandom_range(0, 63) == 0;
      arb = $urandom_range(0, 15) != 0;
      force_g = N'($urandom);
      step();
    end
    arb = 1;
    repeat (25) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
